// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer receive path.
package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

    localparam int TDM_NCH_DEFAULT   = 8;
    localparam int TDM_WIDTH_DEFAULT = 1;

endpackage

// File: rtl/tdm_demux_8ch_slot_decoder.sv
// One-hot shadow-bank write enable from the slot index; inverse of the 8:1 mux select.
module slot_decoder #(
    parameter int NCH   = 8,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    output logic [NCH-1:0]   we
);

    // Indices >= NCH (the parity slot) decode to no enable.
    always_comb begin
        we = '0;
        for (int k = 0; k < NCH; k++) begin
            if (in_valid && (sel == SEL_W'(k))) begin
                we[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux_8ch.sv
// TDM receive demux: serial slot stream into a shadow bank, published per complete frame.
// Define DEMUX_PARITY_EN to append an even-parity slot after the NCH data slots.
//
// state   | meaning
// HUNT    | idle, waiting for in_sof to start a frame
// COLLECT | slot 0 taken, filling slots 1..NSLOT-1
module tdm_demux_8ch
    import tdm_pkg::*;
#(
    parameter int NCH   = TDM_NCH_DEFAULT,
    parameter int WIDTH = TDM_WIDTH_DEFAULT,
`ifdef DEMUX_PARITY_EN
    localparam int NSLOT = NCH + 1,
`else
    localparam int NSLOT = NCH,
`endif
    localparam int SEL_W = $clog2(NSLOT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sof,
    output logic [NCH*WIDTH-1:0] out,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     sel,
    output logic                 frame_err
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NSLOT - 1);

    tdm_state_t           state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NCH*WIDTH-1:0] shadow_q, shadow_d;
    logic [NCH*WIDTH-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef DEMUX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic [SEL_W-1:0] dec_sel;
    logic             dec_valid;
    logic [NCH-1:0]   we;

    // An SOF always lands in slot 0, even when it aborts a frame in progress.
    assign dec_sel   = in_sof ? '0 : sel_q;
    assign dec_valid = in_valid && (in_sof || (state_q == COLLECT));

    slot_decoder #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_slot_decoder (
        .sel      (dec_sel),
        .in_valid (dec_valid),
        .we       (we)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef DEMUX_PARITY_EN
        par_d       = par_q;
`endif

        for (int k = 0; k < NCH; k++) begin
            if (we[k]) begin
                shadow_d[k*WIDTH +: WIDTH] = in_data;
            end
        end

        if (in_valid) begin
            if (in_sof) begin
                frame_err_d = (state_q == COLLECT);
                state_d     = COLLECT;
                sel_d       = SEL_W'(1);
`ifdef DEMUX_PARITY_EN
                par_d       = ^in_data;
`endif
            end else if (state_q == COLLECT) begin
                if (sel_q == LAST_SLOT) begin
                    state_d = HUNT;
                    sel_d   = '0;
`ifdef DEMUX_PARITY_EN
                    // Parity is carried in bit 0 of the parity slot.
                    if (par_q ^ in_data[0]) begin
                        frame_err_d = 1'b1;
                    end else begin
                        out_d       = shadow_q;
                        out_valid_d = 1'b1;
                    end
`else
                    out_d       = shadow_d;
                    out_valid_d = 1'b1;
`endif
                end else begin
                    sel_d = sel_q + SEL_W'(1);
`ifdef DEMUX_PARITY_EN
                    par_d = par_q ^ (^in_data);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            sel_q       <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
`ifdef DEMUX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sel       = sel_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed bench for tdm_demux_8ch: per-cycle vector table plus multi-cycle sequences.
module tb_tdm_demux_8ch;

`ifdef DEMUX_PARITY_EN
    localparam int SEL_W_TB = 4;
`else
    localparam int SEL_W_TB = 3;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [0:0]          in_data;
    logic                in_sof;
    logic [7:0]          out;
    logic                out_valid;
    logic [SEL_W_TB-1:0] sel;
    logic                frame_err;

    int nvec  = 0;
    int nfail = 0;
    int ov_cnt  = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    tdm_demux_8ch #(
        .NCH   (8),
        .WIDTH (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out       (out),
        .out_valid (out_valid),
        .sel       (sel),
        .frame_err (frame_err)
    );

    typedef struct {
        logic                v;
        logic                s;
        logic                d;
        logic [7:0]          e_out;
        logic                e_ov;
        logic [SEL_W_TB-1:0] e_sel;
        logic                e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic v, input logic s, input logic d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        if (out_valid) ov_cnt++;
        if (frame_err) err_cnt++;
        if (out_valid && frame_err) check("ov_err_exclusive", 32'd1, 32'd0);
    endtask

    task automatic add(input logic v, input logic s, input logic d, input logic [7:0] eo,
                       input logic eov, input int es, input logic ee);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.e_out = eo; r.e_ov = eov;
        r.e_sel = SEL_W_TB'(es); r.e_err = ee;
        tbl.push_back(r);
    endtask

    // Slot k carries f[k]; gap_max>0 inserts (k % (gap_max+1)) idle cycles before slot k.
    task automatic send_frame(input logic [7:0] f, input int gap_max, input logic bad_par);
        for (int k = 0; k < 8; k++) begin
            if (k > 0 && gap_max > 0) begin
                for (int g = 0; g < (k % (gap_max + 1)); g++) step(1'b0, 1'b0, 1'b0);
            end
            step(1'b1, (k == 0), f[k]);
        end
`ifdef DEMUX_PARITY_EN
        step(1'b1, 1'b0, (^f) ^ bad_par);
`else
        if (bad_par) check("bad_par_unsupported", 32'd1, 32'd0);
`endif
    endtask

    initial begin
        int ov0;
        int err0;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'h0);
        check("reset_ov", 32'(out_valid), 32'h0);
        check("reset_sel", 32'(sel), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        rst = 1'b0;

`ifndef DEMUX_PARITY_EN
        // beats without SOF are ignored
        add(1, 0, 1, 8'h00, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, 1, 8'h00, 0, 0, 0);
        // full frame 1,0,1,1,0,0,1,0 -> 8'b0100_1101
        add(1, 1, 1, 8'h00, 0, 1, 0);
        add(1, 0, 0, 8'h00, 0, 2, 0);
        add(1, 0, 1, 8'h00, 0, 3, 0);
        add(1, 0, 1, 8'h00, 0, 4, 0);
        add(1, 0, 0, 8'h00, 0, 5, 0);
        add(1, 0, 0, 8'h00, 0, 6, 0);
        add(1, 0, 1, 8'h00, 0, 7, 0);
        add(1, 0, 0, 8'h4D, 1, 0, 0);
        add(0, 0, 1, 8'h4D, 0, 0, 0);
        // early SOF aborts, then new frame 0,1,1,1,1,1,1,1 -> 8'hFE
        add(1, 1, 1, 8'h4D, 0, 1, 0);
        add(1, 0, 0, 8'h4D, 0, 2, 0);
        add(1, 0, 1, 8'h4D, 0, 3, 0);
        add(1, 0, 1, 8'h4D, 0, 4, 0);
        add(1, 1, 0, 8'h4D, 0, 1, 1);
        add(1, 0, 1, 8'h4D, 0, 2, 0);
        add(1, 0, 1, 8'h4D, 0, 3, 0);
        add(0, 0, 0, 8'h4D, 0, 3, 0);
        add(1, 0, 1, 8'h4D, 0, 4, 0);
        add(1, 0, 1, 8'h4D, 0, 5, 0);
        add(1, 0, 1, 8'h4D, 0, 6, 0);
        add(1, 0, 1, 8'h4D, 0, 7, 0);
        add(1, 0, 1, 8'hFE, 1, 0, 0);
        add(1, 0, 0, 8'hFE, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            check($sformatf("row%0d_out", i), 32'(out), 32'(tbl[i].e_out));
            check($sformatf("row%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("row%0d_sel", i), 32'(sel), 32'(tbl[i].e_sel));
            check($sformatf("row%0d_err", i), 32'(frame_err), 32'(tbl[i].e_err));
        end
`endif

        // gaps of 0..5 idle cycles between slots
        ov0 = ov_cnt; err0 = err_cnt;
        send_frame(8'h4D, 5, 1'b0);
        check("gap_out", 32'(out), 32'h4D);
        check("gap_ov_now", 32'(out_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("gap_ov_once", 32'(ov_cnt - ov0), 32'd1);
        check("gap_no_err", 32'(err_cnt - err0), 32'd0);

        // back-to-back frames: SOF of the second on the cycle right after the pulse
        ov0 = ov_cnt;
        send_frame(8'h3C, 0, 1'b0);
        check("b2b_first_out", 32'(out), 32'h3C);
        send_frame(8'hA5, 0, 1'b0);
        check("b2b_second_out", 32'(out), 32'hA5);
        step(1'b0, 1'b0, 1'b0);
        check("b2b_two_pulses", 32'(ov_cnt - ov0), 32'd2);
        check("b2b_hold", 32'(out), 32'hA5);

        // reset mid-frame after slot 4
        ov0 = ov_cnt;
        step(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b1);
        check("pre_rst_sel", 32'(sel), 32'd5);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_out", 32'(out), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_ov", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 1'b1);
        check("rst_then_no_sof_sel", 32'(sel), 32'h0);
        send_frame(8'h96, 0, 1'b0);
        check("post_rst_out", 32'(out), 32'h96);
        check("post_rst_ov_once", 32'(ov_cnt - ov0), 32'd1);

`ifdef DEMUX_PARITY_EN
        ov0 = ov_cnt; err0 = err_cnt;
        send_frame(8'h4D, 0, 1'b0);
        check("par_ok_out", 32'(out), 32'h4D);
        check("par_ok_ov", 32'(out_valid), 32'h1);
        send_frame(8'h4D ^ 8'h01, 0, 1'b1);
        check("par_bad_err", 32'(frame_err), 32'h1);
        check("par_bad_out_held", 32'(out), 32'h4D);
        check("par_bad_sel", 32'(sel), 32'h0);
        check("par_counts", 32'(ov_cnt - ov0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
